// File: rtl/dm_pkg.sv
// Shared types for the clocked data memory: size encodings, FSM states, latched request.
// Pure declarations plus a misalignment helper; no timing or flow control here.
package dm_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return ((size == SZ_HALF) && addr_lo[0]) ||
               ((size == SZ_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/dm_sync_if.sv
// Request/response bundle between the MEM stage (master) and the data memory (slave).
// Request uses valid/ready; the response is a one-cycle rsp_valid pulse with no back-pressure.
interface dm_sync_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dm_byte_lane.sv
// Byte-lane steering: store byte enables and lane replication, load extraction and extension.
// Purely combinational (zero latency); no flow control.
module dm_byte_lane
    import dm_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    input  logic        unsigned_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_rep_o,
    output logic [31:0] rdata_ext_o,
    output logic        misalign_o
);

    logic [7:0]  ld_b;
    logic [15:0] ld_h;

    always_comb begin
        ld_b        = rword_i[7:0];
        ld_h        = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
        be_o        = 4'b0000;
        wdata_rep_o = '0;
        rdata_ext_o = '0;

        case (addr_lo_i)
            2'd0:    ld_b = rword_i[7:0];
            2'd1:    ld_b = rword_i[15:8];
            2'd2:    ld_b = rword_i[23:16];
            default: ld_b = rword_i[31:24];
        endcase

        // Store data is replicated to every lane so the enables alone pick the target bytes.
        case (size_i)
            SZ_BYTE: begin
                be_o        = 4'b0001 << addr_lo_i;
                wdata_rep_o = {4{wdata_i[7:0]}};
                rdata_ext_o = {{24{ld_b[7] & ~unsigned_i}}, ld_b};
            end
            SZ_HALF: begin
                be_o        = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_rep_o = {2{wdata_i[15:0]}};
                rdata_ext_o = {{16{ld_h[15] & ~unsigned_i}}, ld_h};
            end
            SZ_WORD: begin
                be_o        = 4'b1111;
                wdata_rep_o = wdata_i;
                rdata_ext_o = rword_i;
            end
            default: ;
        endcase
    end

    assign misalign_o = misaligned(size_i, addr_lo_i);

endmodule

// File: rtl/dm_sync.sv
// Clocked data memory: one request per handshake, response WAIT_STATES+1 edges after accept.
// req_ready drops only while counting wait states; the response pulse cannot be stalled.
module dm_sync
    import dm_pkg::*;
#(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic      clk,
    input  logic      rst_n,
    dm_sync_if.slave  bus
);

    localparam int         DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [3:0] WS_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    req_t                    req_q;
    req_t                    in_req;
    req_t                    cmt_req;
    logic                    accept;
    logic                    commit;
    logic [31:0]             rsp_rdata_q;
    logic                    rsp_err_q;
    logic [31:0]             mem_q [DEPTH];

    logic [DEPTH_LOG2-1:0]   idx;
    logic                    oor;
    logic                    err;
    logic [31:0]             rword;
    logic [3:0]              be;
    logic [31:0]             wdata_rep;
    logic [31:0]             ld_data;
    logic                    misalign;

    assign bus.req_ready = rst_n && (state_q != WAIT);
    assign accept        = bus.req_valid && bus.req_ready;

    assign in_req = '{we:    bus.req_we,
                      size:  bus.req_size,
                      uns:   bus.req_unsigned,
                      addr:  bus.req_addr,
                      wdata: bus.req_wdata};

    // With no wait states the commit edge is the accept edge, so the live request is used directly.
    assign cmt_req = (WAIT_STATES == 0) ? in_req : req_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WS_INIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign commit = rst_n && (state_d == RESP);

    assign idx   = cmt_req.addr[DEPTH_LOG2+1:2];
    assign oor   = |(cmt_req.addr >> (DEPTH_LOG2 + 2));
    assign err   = oor || misalign || (cmt_req.size == SZ_ILL);
    assign rword = mem_q[idx];

    dm_byte_lane u_lane (
        .size_i      (cmt_req.size),
        .addr_lo_i   (cmt_req.addr[1:0]),
        .wdata_i     (cmt_req.wdata),
        .rword_i     (rword),
        .unsigned_i  (cmt_req.uns),
        .be_o        (be),
        .wdata_rep_o (wdata_rep),
        .rdata_ext_o (ld_data),
        .misalign_o  (misalign)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            req_q       <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) req_q <= in_req;
            if (commit) begin
                rsp_err_q   <= err;
                rsp_rdata_q <= (err || cmt_req.we) ? 32'd0 : ld_data;
            end
        end
    end

    // Array contents survive reset; a store caught in WAIT never reaches its commit edge.
    always_ff @(posedge clk) begin
        if (commit && cmt_req.we && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_q[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
            end
        end
    end

    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule
